// File: rtl/param_scan_bist.sv
// param_scan_bist: self-test wrapper around a WIDTH x WIDTH unsigned multiplier.
// The operand/product flops form one 2*WIDTH-bit scan chain. An LFSR supplies
// shift-in patterns, a controller FSM sequences shift/capture per pattern,
// and a serial signature register (SISR) compacts every bit leaving the chain.
// The final signature is compared with GOLDEN_SIG to produce pass/fail.
// In IDLE/DONE the chain can be shifted and captured through the ext_* inputs.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        begin a self-test run (sampled in IDLE/DONE only)
//   ext_scan_en  manual shift request (IDLE/DONE only, wins over ext_capture)
//   ext_scan_in  manual serial data
//   ext_capture  manual capture request (IDLE/DONE only)
//   fault_inj    force captured product bit 0 to 0 (stuck-at-0 model)
//   scan_in      bit currently presented to the chain input
//   scan_out     chain[0]
//   busy         run in progress
//   done         run complete, pass/signature valid
//   pass         signature matched GOLDEN_SIG (valid while done)
//   signature    current SISR contents
//   pattern_cnt  patterns captured so far in the current run
module param_scan_bist #(
  parameter int                  WIDTH        = 4,
  parameter int                  NUM_PATTERNS = 16,
  parameter int                  LFSR_W       = 8,
  parameter logic [LFSR_W-1:0]   LFSR_SEED    = 8'hBD,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS    = 8'h8E,
  parameter int                  SIG_W        = 16,
  parameter logic [SIG_W-1:0]    SIG_TAPS     = 16'h1021,
  parameter logic [SIG_W-1:0]    GOLDEN_SIG   = 16'h0000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                ext_scan_en,
  input  logic                                ext_scan_in,
  input  logic                                ext_capture,
  input  logic                                fault_inj,
  output logic                                scan_in,
  output logic                                scan_out,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [SIG_W-1:0]                    signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_cnt
);

  localparam int L     = 2 * WIDTH;
  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam int BIT_W = $clog2(L + 1);

  localparam logic [CNT_W-1:0] NUM_P    = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(L - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_UNLOAD  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Many-to-one LFSR advance: parity of tapped bits enters at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  // One SISR compaction step for the bit leaving the chain.
  function automatic logic [SIG_W-1:0] sisr_step(input logic [SIG_W-1:0] s, input logic b);
    logic fb;
    fb = s[SIG_W-1] ^ b;
    return {s[SIG_W-2:0], 1'b0} ^ ({SIG_W{fb}} & SIG_TAPS);
  endfunction

  // Full-width product of the two chain halves; fault model clears bit 0.
  function automatic logic [L-1:0] capture_val(input logic [L-1:0] c, input logic fi);
    logic [L-1:0] p;
    p = {{WIDTH{1'b0}}, c[L-1:WIDTH]} * {{WIDTH{1'b0}}, c[WIDTH-1:0]};
    if (fi) begin
      p[0] = 1'b0;
    end else begin
      p[0] = p[0];
    end
    return p;
  endfunction

  logic [2:0]        state_r,   state_nxt;
  logic [L-1:0]      chain_r,   chain_nxt;
  logic [LFSR_W-1:0] lfsr_r,    lfsr_nxt;
  logic [SIG_W-1:0]  sig_r,     sig_nxt;
  logic [CNT_W-1:0]  cnt_r,     cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt_r, bit_nxt;
  logic              busy_r,    busy_nxt;
  logic              done_r,    done_nxt;
  logic              pass_r,    pass_nxt;
  logic              scan_in_s;

  // Next-state logic for the controller, chain, LFSR, SISR and status flags.
  always_comb begin
    state_nxt = state_r;
    chain_nxt = chain_r;
    lfsr_nxt  = lfsr_r;
    sig_nxt   = sig_r;
    cnt_nxt   = cnt_r;
    bit_nxt   = bit_cnt_r;
    busy_nxt  = busy_r;
    done_nxt  = done_r;
    pass_nxt  = pass_r;
    scan_in_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Manual access; signature/done/pass are deliberately left alone.
        scan_in_s = ext_scan_in;
        if (ext_scan_en) begin
          chain_nxt = {scan_in_s, chain_r[L-1:1]};
        end else if (ext_capture) begin
          chain_nxt = capture_val(chain_r, fault_inj);
        end else begin
          chain_nxt = chain_r;
        end
        if (start) begin
          state_nxt = ST_INIT;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_INIT: begin
        chain_nxt = {L{1'b0}};
        sig_nxt   = {SIG_W{1'b0}};
        lfsr_nxt  = LFSR_SEED;
        cnt_nxt   = {CNT_W{1'b0}};
        bit_nxt   = {BIT_W{1'b0}};
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        scan_in_s = lfsr_r[LFSR_W-1];
        chain_nxt = {scan_in_s, chain_r[L-1:1]};
        sig_nxt   = sisr_step(sig_r, chain_r[0]);
        lfsr_nxt  = lfsr_step(lfsr_r);
        if (bit_cnt_r == LAST_BIT) begin
          bit_nxt   = {BIT_W{1'b0}};
          state_nxt = ST_CAPTURE;
        end else begin
          bit_nxt   = bit_cnt_r + BIT_ONE;
        end
      end
      ST_CAPTURE: begin
        chain_nxt = capture_val(chain_r, fault_inj);
        cnt_nxt   = cnt_r + CNT_ONE;
        // Decision uses the incremented count so exactly NUM_PATTERNS captures occur.
        if ((cnt_r + CNT_ONE) < NUM_P) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        scan_in_s = 1'b0;
        chain_nxt = {scan_in_s, chain_r[L-1:1]};
        sig_nxt   = sisr_step(sig_r, chain_r[0]);
        if (bit_cnt_r == LAST_BIT) begin
          bit_nxt   = {BIT_W{1'b0}};
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          // Compare against the signature that includes this final bit.
          pass_nxt  = (sig_nxt == GOLDEN_SIG);
        end else begin
          bit_nxt   = bit_cnt_r + BIT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      chain_r   <= {L{1'b0}};
      lfsr_r    <= LFSR_SEED;
      sig_r     <= {SIG_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      chain_r   <= chain_nxt;
      lfsr_r    <= lfsr_nxt;
      sig_r     <= sig_nxt;
      cnt_r     <= cnt_nxt;
      bit_cnt_r <= bit_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      pass_r    <= pass_nxt;
    end
  end

  assign scan_in     = scan_in_s;
  assign scan_out    = chain_r[0];
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign signature   = sig_r;
  assign pattern_cnt = cnt_r;

endmodule
